// File: rtl/rggen_irq_pkg.sv
// rtl/rggen_irq_pkg.sv - shared helpers for the interrupt source capture front end
package rggen_irq_pkg;

    localparam int RGGEN_IRQ_MAX_SYNC_STAGES = 3;

    function automatic logic rggen_irq_edge_detect(
        input logic s,
        input logic p,
        input logic falling
    );
        return falling ? (~s & p) : (s & ~p);
    endfunction

    // A single flop is not a valid synchroniser, so 1 is rejected along with anything above 3.
    function automatic bit rggen_irq_sync_stages_legal(input int stages);
        return (stages == 0) || (stages == 2) || (stages == RGGEN_IRQ_MAX_SYNC_STAGES);
    endfunction

endpackage

// File: rtl/rggen_irq_synchronizer.sv
// rtl/rggen_irq_synchronizer.sv - per-bit flop chain synchroniser with zero-stage bypass
module rggen_irq_synchronizer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_chain
        logic [WIDTH-1:0] stage [STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < STAGES; k++) begin
                    stage[k] <= '0;
                end
            end else begin
                stage[0] <= d;
                for (int k = 1; k < STAGES; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
        end

        assign q = stage[STAGES-1];
    end

endmodule

// File: rtl/rggen_irq_source_capture.sv
// rtl/rggen_irq_source_capture.sv - captures raw interrupt sources into sticky/level status with overflow
module rggen_irq_source_capture
    import rggen_irq_pkg::*;
#(
    parameter int                          TOTAL_INTERRUPTS = 1,
    parameter int                          SYNC_STAGES      = 2,
    parameter logic [TOTAL_INTERRUPTS-1:0] EDGE_MASK        = '0,
    parameter logic [TOTAL_INTERRUPTS-1:0] FALLING_MASK     = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [TOTAL_INTERRUPTS-1:0] i_irq_src,
    input  logic [TOTAL_INTERRUPTS-1:0] i_isr_clear,
    input  logic [TOTAL_INTERRUPTS-1:0] i_isr_set,
    input  logic [TOTAL_INTERRUPTS-1:0] i_ovf_clear,
    output logic [TOTAL_INTERRUPTS-1:0] o_isr,
    output logic [TOTAL_INTERRUPTS-1:0] o_overflow
);

    localparam bit SYNC_LEGAL = rggen_irq_sync_stages_legal(SYNC_STAGES);

    if (!SYNC_LEGAL) begin : g_bad_sync_stages
        $error("rggen_irq_source_capture: SYNC_STAGES must be 0, 2 or 3");
    end

    logic [TOTAL_INTERRUPTS-1:0] s;
    logic [TOTAL_INTERRUPTS-1:0] p;

    rggen_irq_synchronizer #(
        .WIDTH  (TOTAL_INTERRUPTS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_irq_src),
        .q     (s)
    );

    // History resets to 0 so a rising source already high at release yields one event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else begin
            p <= s;
        end
    end

    for (genvar i = 0; i < TOTAL_INTERRUPTS; i++) begin : g_bit
        logic ev;
        logic isr_q;
        logic ovf_q;
        logic edge_isr_next;
        logic edge_ovf_next;

        assign ev = rggen_irq_edge_detect(s[i], p[i], FALLING_MASK[i]);

        // A clear in the same cycle consumes the old event, so the new one is not a miss.
        assign edge_isr_next = (ev | i_isr_set[i]) ? 1'b1 :
                               i_isr_clear[i]      ? 1'b0 : isr_q;
        assign edge_ovf_next = (ev & isr_q & ~i_isr_clear[i]) ? 1'b1 :
                               i_ovf_clear[i]                 ? 1'b0 : ovf_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                isr_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                isr_q <= EDGE_MASK[i] ? edge_isr_next : s[i];
                ovf_q <= EDGE_MASK[i] ? edge_ovf_next : 1'b0;
            end
        end

        assign o_isr[i]      = isr_q;
        assign o_overflow[i] = ovf_q;
    end

endmodule

// File: tb/tb_rggen_irq_source_capture.sv
// tb/tb_rggen_irq_source_capture.sv - self-checking bench for rggen_irq_source_capture
module tb_rggen_irq_source_capture;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam logic [N-1:0] EDGE_CFG = 4'b0011;
    localparam logic [N-1:0] FALL_CFG = 4'b0010;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] src   = '0;
    logic [N-1:0] clr   = '0;
    logic [N-1:0] set   = '0;
    logic [N-1:0] oclr  = '0;
    logic [N-1:0] isr;
    logic [N-1:0] ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rggen_irq_source_capture #(
        .TOTAL_INTERRUPTS (N),
        .SYNC_STAGES      (SYNC),
        .EDGE_MASK        (EDGE_CFG),
        .FALLING_MASK     (FALL_CFG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_irq_src   (src),
        .i_isr_clear (clr),
        .i_isr_set   (set),
        .i_ovf_clear (oclr),
        .o_isr       (isr),
        .o_overflow  (ovf)
    );

    // Reference model: delay line of sampled sources, then the status rules bit by bit.
    logic [N-1:0] m_isr, m_ovf, m_prev;
    logic [N-1:0] m_line [$];
    logic [N-1:0] edge_v = EDGE_CFG;
    logic [N-1:0] fall_v = FALL_CFG;

    always @(posedge clk or negedge rst_n) begin : model
        logic [N-1:0] s;
        logic ev;
        if (!rst_n) begin
            m_line.delete();
            m_prev = '0;
            m_isr  = '0;
            m_ovf  = '0;
        end else begin
            while (m_line.size() < SYNC) m_line.push_back('0);
            m_line.push_back(src);
            s = m_line.pop_front();
            for (int i = 0; i < N; i++) begin
                ev = fall_v[i] ? (!s[i] && m_prev[i]) : (s[i] && !m_prev[i]);
                if (!edge_v[i]) begin
                    m_isr[i] = s[i];
                    m_ovf[i] = 1'b0;
                end else begin
                    if (ev && m_isr[i] && !clr[i]) m_ovf[i] = 1'b1;
                    else if (oclr[i])               m_ovf[i] = 1'b0;
                    if (ev || set[i])               m_isr[i] = 1'b1;
                    else if (clr[i])                m_isr[i] = 1'b0;
                end
            end
            m_prev = s;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (isr !== 4'b0000 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state isr=%b ovf=%b expected 0000/0000", isr, ovf);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_rising();
        src[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (isr !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL rise_latency edge=%0d isr=%b expected %b", k, isr, (k == 3) ? 4'b0001 : 4'b0000);
            end
        end
        src[0] = 1'b0;
        tick(4);
        checks++;
        if (isr !== 4'b0001) begin
            failures++;
            $display("FAIL rise_sticky isr=%b expected 0001", isr);
        end
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        checks++;
        if (isr !== 4'b0000) begin
            failures++;
            $display("FAIL rise_clear isr=%b expected 0000", isr);
        end
    endtask

    task automatic test_falling();
        src[1] = 1'b1;
        tick(5);
        checks++;
        if (isr[1] !== 1'b0) begin
            failures++;
            $display("FAIL fall_no_rise_capture isr=%b expected bit1=0", isr);
        end
        src[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (isr[1] !== (k == 3)) begin
                failures++;
                $display("FAIL fall_latency edge=%0d isr1=%b expected %b", k, isr[1], (k == 3));
            end
        end
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        checks++;
        if (isr !== 4'b0000) begin
            failures++;
            $display("FAIL fall_clear isr=%b expected 0000", isr);
        end
    endtask

    task automatic test_level();
        for (int k = 1; k <= 9; k++) begin
            src[2] = (k <= 5);
            clr[2] = (k == 4);
            tick();
            clr[2] = 1'b0;
            checks++;
            if (isr[2] !== (k >= 3 && k <= 7) || ovf[2] !== 1'b0) begin
                failures++;
                $display("FAIL level_follow cycle=%0d isr2=%b ovf2=%b expected %b/0", k, isr[2], ovf[2], (k >= 3 && k <= 7));
            end
        end
    endtask

    task automatic test_overflow();
        src[0] = 1'b1; tick(3);
        src[0] = 1'b0; tick(3);
        src[0] = 1'b1; tick(3);
        checks++;
        if (isr !== 4'b0001 || ovf !== 4'b0001) begin
            failures++;
            $display("FAIL ovf_second_edge isr=%b ovf=%b expected 0001/0001", isr, ovf);
        end
        src[0] = 1'b0; tick(3);
        src[0] = 1'b1; tick(2);
        clr[0] = 1'b1; tick();
        clr[0] = 1'b0;
        checks++;
        if (isr !== 4'b0001 || ovf !== 4'b0001) begin
            failures++;
            $display("FAIL ovf_edge_with_clear isr=%b ovf=%b expected 0001/0001", isr, ovf);
        end
        oclr[0] = 1'b1; tick();
        oclr[0] = 1'b0;
        checks++;
        if (isr !== 4'b0001 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_clear isr=%b ovf=%b expected 0001/0000", isr, ovf);
        end
        src[0] = 1'b0; tick(3);
    endtask

    task automatic test_set_clear();
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        checks++;
        if (isr !== 4'b0000) begin
            failures++;
            $display("FAIL sw_clear isr=%b expected 0000", isr);
        end
        set[0] = 1'b1; clr[0] = 1'b1; tick();
        set[0] = 1'b0; clr[0] = 1'b0;
        checks++;
        if (isr !== 4'b0001 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL set_beats_clear isr=%b ovf=%b expected 0001/0000", isr, ovf);
        end
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        set[0] = 1'b1; tick(); set[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (isr !== 4'b0000 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset isr=%b ovf=%b expected 0000/0000", isr, ovf);
        end
        src = 4'b0011;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (isr !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL release_capture edge=%0d isr=%b expected %b", k, isr, (k == 3) ? 4'b0001 : 4'b0000);
            end
        end
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        tick(5);
        checks++;
        if (isr !== 4'b0000) begin
            failures++;
            $display("FAIL release_single_capture isr=%b expected 0000", isr);
        end
        src = '0;
        tick(4);
    endtask

    task automatic test_random();
        int mism = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) src[i] = ~src[i];
            end
            clr  = N'($urandom & $urandom & $urandom);
            set  = N'($urandom & $urandom & $urandom & $urandom);
            oclr = N'($urandom & $urandom & $urandom);
            tick();
            checks++;
            if (isr !== m_isr || ovf !== m_ovf) begin
                failures++;
                mism++;
                if (mism <= 10)
                    $display("FAIL random_vs_model cycle=%0d isr=%b ovf=%b expected %b/%b", c, isr, ovf, m_isr, m_ovf);
            end
        end
        clr = '0; set = '0; oclr = '0; src = '0;
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_level();
        test_overflow();
        test_set_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
